// File: rtl/dcache_fill_ctrl.sv
// Write-port controller for the dcache SRAM: shares one registered write port
// between core stores (one row per request) and a line-fill engine (one beat per word).
module dcache_fill_ctrl #(
    parameter int WIDTH        = 512,
    parameter int LOG_NUM_ROWS = 9,
    parameter int WORD_SIZE    = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fill_req_valid,
    output logic                          fill_req_ready,
    input  logic [LOG_NUM_ROWS-1:0]       fill_req_row,
    input  logic                          beat_valid,
    output logic                          beat_ready,
    input  logic [WORD_SIZE-1:0]          beat_data,
    output logic                          fill_done,
    output logic [LOG_NUM_ROWS-1:0]       fill_done_row,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [LOG_NUM_ROWS-1:0]       st_row,
    input  logic [WIDTH-1:0]              st_data,
    input  logic [WIDTH/WORD_SIZE-1:0]    st_we,
    output logic [LOG_NUM_ROWS-1:0]       sram_writeAddr,
    output logic [WIDTH-1:0]              sram_writeData,
    output logic [WIDTH/WORD_SIZE-1:0]    sram_writeEnable
);

    localparam int NWORDS   = WIDTH / WORD_SIZE;
    localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [LOG_NUM_ROWS-1:0] fill_row_q, fill_row_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [STARVE_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                    fill_done_q, fill_done_d;
    logic [LOG_NUM_ROWS-1:0] fill_done_row_q, fill_done_row_d;
    logic [LOG_NUM_ROWS-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]        wr_data_q, wr_data_d;
    logic [NWORDS-1:0]       wr_en_q, wr_en_d;

    logic row_hit;
    logic starved;
    logic store_wins;
    logic st_hs;
    logic beat_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            fill_row_q      <= '0;
            beat_cnt_q      <= '0;
            starve_cnt_q    <= '0;
            fill_done_q     <= 1'b0;
            fill_done_row_q <= '0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_en_q         <= '0;
        end else begin
            state_q         <= state_d;
            fill_row_q      <= fill_row_d;
            beat_cnt_q      <= beat_cnt_d;
            starve_cnt_q    <= starve_cnt_d;
            fill_done_q     <= fill_done_d;
            fill_done_row_q <= fill_done_row_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_en_q         <= wr_en_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        fill_row_d      = fill_row_q;
        beat_cnt_d      = beat_cnt_q;
        starve_cnt_d    = starve_cnt_q;
        fill_done_d     = 1'b0;
        fill_done_row_d = fill_done_row_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        wr_en_d         = '0;
        fill_req_ready  = 1'b0;
        beat_ready      = 1'b0;
        st_ready        = 1'b1;

        // A store to the row being filled would be clobbered by later beats.
        row_hit    = (st_row == fill_row_q);
        starved    = (starve_cnt_q >= STARVE_W'(STARVE_LIMIT));
        store_wins = beat_valid && st_valid && !row_hit && !starved;

        case (state_q)
            S_IDLE: begin
                fill_req_ready = 1'b1;
                if (fill_req_valid) begin
                    state_d      = S_FILL;
                    fill_row_d   = fill_req_row;
                    beat_cnt_d   = '0;
                    starve_cnt_d = '0;
                end
            end
            S_FILL: begin
                st_ready   = !row_hit && !(beat_valid && starved);
                beat_ready = !store_wins;
                if (beat_valid && beat_ready) begin
                    beat_cnt_d   = beat_cnt_q + CNT_W'(1);
                    starve_cnt_d = '0;
                    if (beat_cnt_q == CNT_W'(NWORDS - 1)) begin
                        state_d = S_DONE;
                    end
                end else if (store_wins) begin
                    starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                end
            end
            S_DONE: begin
                state_d         = S_IDLE;
                fill_done_d     = 1'b1;
                fill_done_row_d = fill_row_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Arbitration above guarantees at most one of these per cycle.
        st_hs   = st_valid && st_ready;
        beat_hs = beat_valid && beat_ready;
        if (st_hs) begin
            wr_addr_d = st_row;
            wr_data_d = st_data;
            wr_en_d   = st_we;
        end else if (beat_hs) begin
            wr_addr_d = fill_row_q;
            wr_data_d = {NWORDS{beat_data}};
            wr_en_d   = NWORDS'(1) << beat_cnt_q;
        end
    end

    // fill_done follows the DONE cycle, so it rises once the last beat is committed.
    assign fill_done        = fill_done_q;
    assign fill_done_row    = fill_done_row_q;
    assign sram_writeAddr   = wr_addr_q;
    assign sram_writeData   = wr_data_q;
    assign sram_writeEnable = wr_en_q;

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Bench for dcache_fill_ctrl: IDLE vector table, directed fill/store sequences and a
// randomized run, all checked against a transaction-level model of the write port.
module tb_dcache_fill_ctrl;

    localparam int WIDTH = 512;
    localparam int LNR   = 9;
    localparam int WS    = 64;
    localparam int NW    = WIDTH / WS;
    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             fill_req_valid;
    logic             fill_req_ready;
    logic [LNR-1:0]   fill_req_row;
    logic             beat_valid;
    logic             beat_ready;
    logic [WS-1:0]    beat_data;
    logic             fill_done;
    logic [LNR-1:0]   fill_done_row;
    logic             st_valid;
    logic             st_ready;
    logic [LNR-1:0]   st_row;
    logic [WIDTH-1:0] st_data;
    logic [NW-1:0]    st_we;
    logic [LNR-1:0]   sram_writeAddr;
    logic [WIDTH-1:0] sram_writeData;
    logic [NW-1:0]    sram_writeEnable;

    dcache_fill_ctrl #(
        .WIDTH(WIDTH), .LOG_NUM_ROWS(LNR), .WORD_SIZE(WS), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
        .fill_req_row(fill_req_row),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .fill_done(fill_done), .fill_done_row(fill_done_row),
        .st_valid(st_valid), .st_ready(st_ready), .st_row(st_row),
        .st_data(st_data), .st_we(st_we),
        .sram_writeAddr(sram_writeAddr), .sram_writeData(sram_writeData),
        .sram_writeEnable(sram_writeEnable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a fill is a transaction with a row, a count of beats written
    // and a count of stores that jumped ahead of the waiting beat.
    bit               m_filling;
    bit               m_done;
    int               m_row;
    int               m_beats;
    int               m_won;
    logic [NW-1:0]    e_en;
    logic [LNR-1:0]   e_addr;
    logic [WIDTH-1:0] e_data;
    bit               e_done;
    logic [LNR-1:0]   e_done_row;

    bit o_st_ready;
    bit o_beat_ready;

    typedef struct {
        logic           sv;
        logic [LNR-1:0] row;
        logic [NW-1:0]  we;
        logic           bv;
        logic           x_st_rdy;
        logic           x_beat_rdy;
        logic [NW-1:0]  x_en;
        logic [LNR-1:0] x_addr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_row();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_filling  = 0;
        m_done     = 0;
        m_row      = 0;
        m_beats    = 0;
        m_won      = 0;
        e_en       = '0;
        e_addr     = '0;
        e_data     = '0;
        e_done     = 0;
        e_done_row = '0;
    endtask

    // One clock: check last cycle's registered outputs, drive new inputs, check the
    // handshake signals, then advance the model by what should have been accepted.
    task automatic step(input logic frv, input logic [LNR-1:0] frr,
                        input logic bv, input logic [WS-1:0] bd,
                        input logic sv, input logic [LNR-1:0] sr,
                        input logic [WIDTH-1:0] sd, input logic [NW-1:0] swe);
        bit idle, conflict, starved, store_wins, x_st, x_bt, st_hs, bt_hs, fl_hs;
        @(negedge clk);
        check("wr_en", sram_writeEnable, e_en);
        check("wr_addr", sram_writeAddr, e_addr);
        check("wr_data", sram_writeData, e_data);
        check("fill_done", fill_done, e_done);
        if (e_done) check("fill_done_row", fill_done_row, e_done_row);

        fill_req_valid = frv; fill_req_row = frr;
        beat_valid = bv; beat_data = bd;
        st_valid = sv; st_row = sr; st_data = sd; st_we = swe;
        #1;

        idle = !m_filling && !m_done;
        store_wins = 0;
        if (m_filling) begin
            conflict   = (int'(sr) == m_row);
            starved    = (m_won >= LIMIT);
            store_wins = sv && bv && !conflict && !starved;
            x_bt       = !store_wins;
            x_st       = !conflict && !(bv && starved);
        end else begin
            x_st = 1;
            x_bt = 0;
        end
        check("fill_req_ready", fill_req_ready, idle);
        if (sv) check("st_ready", st_ready, x_st);
        if (bv) check("beat_ready", beat_ready, x_bt);
        o_st_ready   = st_ready;
        o_beat_ready = beat_ready;

        st_hs = sv && x_st;
        bt_hs = bv && x_bt;
        fl_hs = frv && idle;

        e_done = m_done;
        if (m_done) e_done_row = LNR'(m_row);
        if (st_hs) begin
            e_en = swe; e_addr = sr; e_data = sd;
        end else if (bt_hs) begin
            e_en = NW'(1) << m_beats;
            e_addr = LNR'(m_row);
            for (int w = 0; w < NW; w++) e_data[w*WS +: WS] = bd;
        end else begin
            e_en = '0;
        end

        if (m_done) begin
            m_done = 0;
        end else if (fl_hs) begin
            m_filling = 1; m_row = int'(frr); m_beats = 0; m_won = 0;
        end else if (m_filling) begin
            if (bt_hs) begin
                m_beats++;
                m_won = 0;
                if (m_beats == NW) begin
                    m_filling = 0;
                    m_done    = 1;
                end
            end else if (store_wins) begin
                m_won++;
            end
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        bit got;
        tbl[0] = '{1'b1, 9'd3,   8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 9'd3};
        tbl[1] = '{1'b1, 9'd10,  8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 9'd10};
        tbl[2] = '{1'b0, 9'd20,  8'hff, 1'b1, 1'b1, 1'b0, 8'h00, 9'd10};
        tbl[3] = '{1'b1, 9'd511, 8'hff, 1'b0, 1'b1, 1'b0, 8'hff, 9'd511};
        tbl[4] = '{1'b1, 9'd0,   8'h3c, 1'b1, 1'b1, 1'b0, 8'h3c, 9'd0};
        tbl[5] = '{1'b0, 9'd7,   8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0};

        reset = 1;
        fill_req_valid = 0; fill_req_row = '0; beat_valid = 0; beat_data = '0;
        st_valid = 0; st_row = '0; st_data = '0; st_we = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_wr_en", sram_writeEnable, 0);
        check("rst_wr_addr", sram_writeAddr, 0);
        check("rst_wr_data", sram_writeData, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_fill_done_row", fill_done_row, 0);
        check("rst_fill_req_ready", fill_req_ready, 1);
        reset = 0;

        // IDLE store vectors, including an all-zero write mask
        for (int i = 0; i < 6; i++) begin
            step(0, '0, tbl[i].bv, 64'hdead, tbl[i].sv, tbl[i].row, rand_row(), tbl[i].we);
            check("tbl_st_ready", o_st_ready, tbl[i].x_st_rdy);
            check("tbl_beat_ready", o_beat_ready, tbl[i].x_beat_rdy);
            @(posedge clk); #1;
            check("tbl_wr_en", sram_writeEnable, tbl[i].x_en);
            check("tbl_wr_addr", sram_writeAddr, tbl[i].x_addr);
        end

        // Plain fill of row 5, beats 0x10..0x17
        step(1, 9'd5, 0, '0, 0, '0, '0, '0);
        for (int k = 0; k < NW; k++) step(0, '0, 1, WS'(16 + k), 0, '0, '0, '0);
        idle_steps(3);

        // Store to the row under fill waits for the DONE cycle
        step(1, 9'd7, 0, '0, 0, '0, '0, '0);
        stall = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(0, '0, 1, WS'(112 + k), 1, 9'd7, {16{32'hc0ffee00 + 32'(k)}}, 8'h5a);
            if (o_st_ready) got = 1;
            else stall++;
        end
        check("t3_store_accepted", got, 1);
        check("t3_stall_cycles", stall, NW);
        idle_steps(3);

        // Contending store to another row wins LIMIT cycles, then a beat is forced
        step(1, 9'd2, 0, '0, 0, '0, '0, '0);
        for (int k = 0; k < NW * (LIMIT + 1); k++) begin
            step(0, '0, 1, WS'(32 + k), 1, 9'd9, rand_row(), 8'hff);
            check("t4_beat_pattern", o_beat_ready, (k % (LIMIT + 1)) == LIMIT);
        end
        idle_steps(3);

        // Reset after the third beat abandons the fill
        step(1, 9'd4, 0, '0, 0, '0, '0, '0);
        for (int k = 0; k < 3; k++) step(0, '0, 1, WS'(64 + k), 0, '0, '0, '0);
        @(negedge clk);
        fill_req_valid = 0; beat_valid = 0; st_valid = 0;
        reset = 1;
        #1;
        check("t5_wr_en", sram_writeEnable, 0);
        check("t5_wr_addr", sram_writeAddr, 0);
        check("t5_wr_data", sram_writeData, 0);
        check("t5_fill_done", fill_done, 0);
        check("t5_fill_done_row", fill_done_row, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        idle_steps(NW + 4);

        // Randomized traffic with a small row range so conflicts are common
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, LNR'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, LNR'($urandom_range(0, 3)),
                 rand_row(), NW'($urandom));
        end
        idle_steps(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
